// File: rtl/vga_rect_arbiter.sv
// vga_rect_arbiter: shares the VGA adapter write port among NUM_REQ
// rectangle-fill clients. Clients are granted round-robin and the granted
// rectangle is rasterised at one pixel per clock, column fastest.
// Build option: define VGA_RECT_CLIP_EN to suppress pixels that fall outside
// SCREEN_W x SCREEN_H (the sweep still takes w*h cycles).
module vga_rect_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [8*NUM_REQ-1:0]  req_x0,
    input  logic [7*NUM_REQ-1:0]  req_y0,
    input  logic [8*NUM_REQ-1:0]  req_w,
    input  logic [7*NUM_REQ-1:0]  req_h,
    input  logic [24*NUM_REQ-1:0] req_color,
    output logic [7:0]            VGA_X,
    output logic [6:0]            VGA_Y,
    output logic [23:0]           VGA_COLOR,
    output logic                  plot,
    output logic                  busy,
    output logic [NUM_REQ-1:0]    done
);
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 24;
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // The carry bit of each coordinate sum is only needed by the clip check.
`ifdef VGA_RECT_CLIP_EN
    localparam int unsigned XSW = XW + 1;
    localparam int unsigned YSW = YW + 1;
`else
    localparam int unsigned XSW = XW;
    localparam int unsigned YSW = YW;
`endif

    typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

    state_t             state, state_d;
    logic [IW-1:0]      last_grant, last_grant_d;
    logic [XW-1:0]      x0, x0_d, w, w_d, col, col_d;
    logic [YW-1:0]      y0, y0_d, h, h_d, row, row_d;
    logic [CW-1:0]      color, color_d;
    logic               fin, fin_d;
    logic [NUM_REQ-1:0] req_ready_d, done_d, grant_oh;
    logic [XW-1:0]      vga_x_d;
    logic [YW-1:0]      vga_y_d;
    logic [CW-1:0]      vga_color_d;
    logic               plot_d, busy_d;

    logic [XW-1:0]      x0_a    [NUM_REQ];
    logic [YW-1:0]      y0_a    [NUM_REQ];
    logic [XW-1:0]      w_a     [NUM_REQ];
    logic [YW-1:0]      h_a     [NUM_REQ];
    logic [CW-1:0]      color_a [NUM_REQ];
    logic               found;
    logic [IW-1:0]      win;
    int unsigned        idx;
    logic [XSW-1:0]     xs;
    logic [YSW-1:0]     ys;

    assign grant_oh = NUM_REQ'(1) << last_grant;
    assign xs       = XSW'(x0) + XSW'(col);
    assign ys       = YSW'(y0) + YSW'(row);

    // Unpack the flat per-client request buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            x0_a[i]    = req_x0[XW*i +: XW];
            y0_a[i]    = req_y0[YW*i +: YW];
            w_a[i]     = req_w[XW*i +: XW];
            h_a[i]     = req_h[YW*i +: YW];
            color_a[i] = req_color[CW*i +: CW];
        end
    end

    // Round-robin search starting one past the last granted client.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(last_grant) + 32'd1 + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        x0_d         = x0;
        y0_d         = y0;
        w_d          = w;
        h_d          = h;
        color_d      = color;
        col_d        = col;
        row_d        = row;
        fin_d        = fin;
        req_ready_d  = '0;
        done_d       = '0;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        vga_x_d      = VGA_X;
        vga_y_d      = VGA_Y;
        vga_color_d  = VGA_COLOR;
        case (state)
            IDLE: begin
                // A ready seen while still IDLE means a zero-size grant: the
                // client still holds valid this cycle, so finish it instead of re-arbitrating.
                if (|req_ready) begin
                    done_d = req_ready;
                end else if (found) begin
                    req_ready_d  = NUM_REQ'(1) << win;
                    last_grant_d = win;
                    x0_d         = x0_a[win];
                    y0_d         = y0_a[win];
                    w_d          = w_a[win];
                    h_d          = h_a[win];
                    color_d      = color_a[win];
                    col_d        = '0;
                    row_d        = '0;
                    fin_d        = 1'b0;
                    if (w_a[win] != '0 && h_a[win] != '0) state_d = DRAW;
                end
            end
            DRAW: begin
                if (fin) begin
                    done_d  = grant_oh;
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
`ifdef VGA_RECT_CLIP_EN
                    if (xs < XSW'(SCREEN_W) && ys < YSW'(SCREEN_H)) begin
                        plot_d      = 1'b1;
                        vga_x_d     = xs[XW-1:0];
                        vga_y_d     = ys[YW-1:0];
                        vga_color_d = color;
                    end
`else
                    plot_d      = 1'b1;
                    vga_x_d     = xs;
                    vga_y_d     = ys;
                    vga_color_d = color;
`endif
                    if (col == w - 8'd1) begin
                        col_d = '0;
                        if (row == h - 7'd1) fin_d = 1'b1;
                        else                 row_d = row + 7'd1;
                    end else begin
                        col_d = col + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; the pointer resets so client 0 wins first.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            x0         <= '0;
            y0         <= '0;
            w          <= '0;
            h          <= '0;
            color      <= '0;
            col        <= '0;
            row        <= '0;
            fin        <= 1'b0;
            req_ready  <= '0;
            done       <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            x0         <= x0_d;
            y0         <= y0_d;
            w          <= w_d;
            h          <= h_d;
            color      <= color_d;
            col        <= col_d;
            row        <= row_d;
            fin        <= fin_d;
            req_ready  <= req_ready_d;
            done       <= done_d;
            plot       <= plot_d;
            busy       <= busy_d;
            VGA_X      <= vga_x_d;
            VGA_Y      <= vga_y_d;
            VGA_COLOR  <= vga_color_d;
        end
    end

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// tb_vga_rect_arbiter: directed bench for vga_rect_arbiter with hand-computed
// expected pixels, grant orders and handshake timing. Outputs sampled on negedge.
// Honours VGA_RECT_CLIP_EN for the off-screen rectangle expectations.
module tb_vga_rect_arbiter;
    logic        clk;
    logic        resetn;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [23:0] req_x0;
    logic [20:0] req_y0;
    logic [23:0] req_w;
    logic [20:0] req_h;
    logic [71:0] req_color;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [23:0] vga_color;
    logic        plot;
    logic        busy;
    logic [2:0]  done;

    int vectors;
    int miscompares;
    int got[8];
    int got_n;

    vga_rect_arbiter #(.NUM_REQ(3), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .req_valid(valid),
        .req_ready(ready),
        .req_x0   (req_x0),
        .req_y0   (req_y0),
        .req_w    (req_w),
        .req_h    (req_h),
        .req_color(req_color),
        .VGA_X    (vga_x),
        .VGA_Y    (vga_y),
        .VGA_COLOR(vga_color),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int oh2idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] w, input logic [6:0] h, input logic [23:0] c);
        req_x0[8*i +: 8]     = x;
        req_y0[7*i +: 7]     = y;
        req_w[8*i +: 8]      = w;
        req_h[7*i +: 7]      = h;
        req_color[24*i +: 24] = c;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        valid  = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Drive a valid mask and record the winner of each ready pulse.
    // With hold=0 each client drops valid one cycle after its ready.
    task automatic collect_grants(input logic [2:0] mask, input bit hold, input int n);
        logic [2:0] drop;
        drop  = '0;
        got_n = 0;
        valid = mask;
        for (int cyc = 0; cyc < 200 && got_n < n; cyc++) begin
            tick();
            if (!hold) valid = valid & ~drop;
            drop = ready;
            if (ready != 3'b000) begin
                got[got_n] = oh2idx(ready);
                got_n++;
            end
        end
        tick();
        valid = '0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        valid  = '0;
        #3;
        vectors++;
        if ({ready, done, plot, busy} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ready=%b done=%b plot=%b busy=%b, want all 0", ready, done, plot, busy);
        end
        tick();
        resetn = 1'b1;
        tick();
        vectors++;
        if ({vga_x, vga_y, vga_color} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_pix: got x=%0d y=%0d c=%h, want 0", vga_x, vga_y, vga_color);
        end
    endtask

    task automatic test_single();
        set_req(0, 8'd10, 7'd20, 8'd3, 7'd2, 24'hFF0000);
        valid = 3'b001;
        tick();
        vectors++;
        if (ready !== 3'b001 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready: got ready=%b plot=%b, want 001/0", ready, plot);
        end
        tick();
        valid = 3'b000;
        for (int p = 0; p < 6; p++) begin
            if (p > 0) tick();
            vectors++;
            if (plot !== 1'b1 || busy !== 1'b1 || ready !== 3'b000 || done !== 3'b000 ||
                vga_x !== 8'(10 + p % 3) || vga_y !== 7'(20 + p / 3) || vga_color !== 24'hFF0000) begin
                miscompares++;
                $display("FAIL single_pix%0d: got plot=%b busy=%b ready=%b (%0d,%0d) %h, want 1 1 000 (%0d,%0d) ff0000",
                         p, plot, busy, ready, vga_x, vga_y, vga_color, 10 + p % 3, 20 + p / 3);
            end
        end
        tick();
        vectors++;
        if (plot !== 1'b0 || done !== 3'b001 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got plot=%b done=%b busy=%b, want 0/001/0", plot, done, busy);
        end
        tick();
        vectors++;
        if (done !== 3'b000) begin
            miscompares++;
            $display("FAIL single_done_pulse: got done=%b, want 000", done);
        end
    endtask

    task automatic test_round_robin();
        int exp_a[3];
        int exp_b[3];
        exp_a = '{0, 1, 2};
        exp_b = '{1, 2, 1};
        do_reset();
        set_req(0, 8'd1, 7'd1, 8'd1, 7'd1, 24'h000011);
        set_req(1, 8'd2, 7'd2, 8'd1, 7'd1, 24'h000022);
        set_req(2, 8'd3, 7'd3, 8'd1, 7'd1, 24'h000033);
        for (int r = 0; r < 2; r++) begin
            collect_grants(3'b111, 1'b0, 3);
            vectors++;
            if (got_n !== 3) begin
                miscompares++;
                $display("FAIL rr%0d_count: got %0d grants, want 3", r, got_n);
            end
            for (int i = 0; i < got_n && i < 3; i++) begin
                vectors++;
                if (got[i] !== exp_a[i]) begin
                    miscompares++;
                    $display("FAIL rr%0d_grant%0d: got client %0d, want %0d", r, i, got[i], exp_a[i]);
                end
            end
        end
        collect_grants(3'b110, 1'b1, 3);
        vectors++;
        if (got_n !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d grants, want 3", got_n);
        end
        for (int i = 0; i < got_n && i < 3; i++) begin
            vectors++;
            if (got[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: got client %0d, want %0d", i, got[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_zero_size();
        set_req(1, 8'd5, 7'd5, 8'd0, 7'd5, 24'h123456);
        valid = 3'b010;
        tick();
        vectors++;
        if (ready !== 3'b010 || plot !== 1'b0 || busy !== 1'b0 || done !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_ready: got ready=%b plot=%b busy=%b done=%b, want 010 0 0 000", ready, plot, busy, done);
        end
        tick();
        valid = 3'b000;
        vectors++;
        if (ready !== 3'b000 || plot !== 1'b0 || busy !== 1'b0 || done !== 3'b010) begin
            miscompares++;
            $display("FAIL zero_done: got ready=%b plot=%b busy=%b done=%b, want 000 0 0 010", ready, plot, busy, done);
        end
        tick();
        vectors++;
        if (ready !== 3'b000 || plot !== 1'b0 || busy !== 1'b0 || done !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_after: got ready=%b plot=%b busy=%b done=%b, want all 0", ready, plot, busy, done);
        end
    endtask

    task automatic test_clip();
        logic exp_plot;
        set_req(2, 8'd158, 7'd119, 8'd4, 7'd2, 24'h00FF00);
        valid = 3'b100;
        tick();
        vectors++;
        if (ready !== 3'b100) begin
            miscompares++;
            $display("FAIL clip_ready: got ready=%b, want 100", ready);
        end
        tick();
        valid = 3'b000;
        for (int p = 0; p < 8; p++) begin
            if (p > 0) tick();
`ifdef VGA_RECT_CLIP_EN
            exp_plot = (158 + p % 4 < 160) && (119 + p / 4 < 120);
`else
            exp_plot = 1'b1;
`endif
            vectors++;
            if (plot !== exp_plot || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL clip_plot%0d: got plot=%b busy=%b, want %b 1", p, plot, busy, exp_plot);
            end
            vectors++;
            if (exp_plot && (vga_x !== 8'(158 + p % 4) || vga_y !== 7'(119 + p / 4) || vga_color !== 24'h00FF00)) begin
                miscompares++;
                $display("FAIL clip_pix%0d: got (%0d,%0d) %h, want (%0d,%0d) 00ff00",
                         p, vga_x, vga_y, vga_color, (158 + p % 4) % 256, (119 + p / 4) % 128);
            end else if (!exp_plot && (vga_x !== 8'd159 || vga_y !== 7'd119)) begin
                miscompares++;
                $display("FAIL clip_hold%0d: got (%0d,%0d), want held (159,119)", p, vga_x, vga_y);
            end
        end
        tick();
        vectors++;
        if (done !== 3'b100 || plot !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clip_done: got done=%b plot=%b busy=%b, want 100 0 0", done, plot, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_draw();
        int seen_done;
        int seen_plot;
        seen_done = 0;
        seen_plot = 0;
        set_req(0, 8'd40, 7'd30, 8'd10, 7'd10, 24'hABCDEF);
        valid = 3'b001;
        tick();
        tick();
        valid = 3'b000;
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (plot !== 1'b1 || vga_x !== 8'd44 || vga_y !== 7'd30) begin
            miscompares++;
            $display("FAIL abort_pre: got plot=%b (%0d,%0d), want 1 (44,30)", plot, vga_x, vga_y);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({plot, busy, done, ready} !== 8'h00 || {vga_x, vga_y, vga_color} !== 39'd0) begin
            miscompares++;
            $display("FAIL abort_now: got plot=%b busy=%b done=%b ready=%b (%0d,%0d) %h, want all 0",
                     plot, busy, done, ready, vga_x, vga_y, vga_color);
        end
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (done != 3'b000) seen_done++;
            if (plot) seen_plot++;
        end
        vectors++;
        if (seen_done != 0 || seen_plot != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d done and %0d plot cycles, want 0 0", seen_done, seen_plot);
        end
        set_req(0, 8'd1, 7'd1, 8'd1, 7'd1, 24'h000011);
        set_req(1, 8'd2, 7'd2, 8'd1, 7'd1, 24'h000022);
        collect_grants(3'b011, 1'b0, 1);
        vectors++;
        if (got_n !== 1 || got[0] !== 0) begin
            miscompares++;
            $display("FAIL abort_prio: got %0d grants first=%0d, want 1 grant to client 0", got_n, got[0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        valid       = '0;
        req_x0      = '0;
        req_y0      = '0;
        req_w       = '0;
        req_h       = '0;
        req_color   = '0;
        for (int i = 0; i < 8; i++) got[i] = -1;
        got_n = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_size();
        test_clip();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
